// File: rtl/top_controlled_decoder_ble.sv
// top_controlled_decoder_ble
// Packet decoder for the (15,10) shortened cyclic Hamming code with
// g(D) = D^5 + D^4 + D^2 + 1. Received bits arrive MSB-first (D^14 first);
// D^14..D^5 carry information, D^4..D^0 carry parity. Each completed block
// is syndrome-checked, a single-bit error is corrected, and the recovered
// information bits are streamed out MSB-first with padding suppressed.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   data_in        received coded bit
//   valid_in       data_in qualifier (one bit per cycle at most)
//   n_bits         payload information bits in the packet (latched on start)
//   enable         run control; dropping it outside IDLE aborts the packet
//   valid_out      data_out carries a decoded information bit
//   data_out       decoded, corrected information bit
//   finished       one-cycle pulse after the last information bit
//   uncorrectable  one-cycle pulse per block with a non-single-bit syndrome
//   corrected_cnt, uncorrectable_cnt  per-packet saturating statistics,
//                  present only when BLE_FEC_ERR_STATS_EN is defined
module top_controlled_decoder_ble #(
  parameter int NB_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_in,
  input  logic            valid_in,
  input  logic [NB_W-1:0] n_bits,
  input  logic            enable,
  output logic            valid_out,
  output logic            data_out,
  output logic            finished,
  output logic            uncorrectable
`ifdef BLE_FEC_ERR_STATS_EN
  ,
  output logic [7:0]      corrected_cnt,
  output logic [7:0]      uncorrectable_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // D^5 reduced modulo g(D)
  localparam logic [4:0]      G_LOW    = 5'b10101;
  localparam logic [NB_W-1:0] BLK_INFO = NB_W'(4'd10);

  state_t            state_r, state_s;
  logic [14:0]       rx_sh_r;
  logic [3:0]        bit_cnt_r;
  logic              blk_full_r;
  logic [NB_W-1:0]   coll_left_r, emit_left_r;
  logic [8:0]        out_sh_r;
  logic [3:0]        out_rem_r;
  logic              valid_out_r, data_out_r, finished_r, uncorr_r;
  logic [4:0]        syn_s, loc_s;
  logic [9:0]        info_mask_s, info_corr_s;
  logic              unc_s, last_done_s;
  logic [NB_W-1:0]   blk_info_s, coll_info_s;

  // Remainder of the received word divided by g(D), processed MSB first.
  function automatic logic [4:0] syndrome(input logic [14:0] word);
    logic [4:0] rem;
    rem = 5'd0;
    for (int i = 14; i >= 0; i--) begin
      if (rem[4]) rem = {rem[3:0], word[i]} ^ G_LOW;
      else        rem = {rem[3:0], word[i]};
    end
    return rem;
  endfunction

  // Finds i with D^i mod g(D) == syn; bit 4 flags a match, bits 3:0 hold i.
  function automatic logic [4:0] locate(input logic [4:0] syn);
    logic [4:0] pow;
    logic [4:0] res;
    pow = 5'b00001;
    res = 5'd0;
    for (int i = 0; i < 15; i++) begin
      if (!res[4] && (pow == syn)) res = {1'b1, 4'(i)};
      else                         res = res;
      if (pow[4]) pow = {pow[3:0], 1'b0} ^ G_LOW;
      else        pow = {pow[3:0], 1'b0};
    end
    return res;
  endfunction

  // Syndrome decode of the completed block; only info-bit errors need fixing.
  always_comb begin
    syn_s = syndrome(rx_sh_r);
    loc_s = locate(syn_s);
    if (loc_s[4] && (loc_s[3:0] >= 4'd5)) info_mask_s = 10'd1 << (loc_s[3:0] - 4'd5);
    else                                  info_mask_s = 10'd0;
    info_corr_s = rx_sh_r[14:5] ^ info_mask_s;
    unc_s       = (syn_s != 5'd0) && !loc_s[4];
  end

  // Info bits carried by the next block on each side, and end-of-packet detect.
  always_comb begin
    if (emit_left_r < BLK_INFO) blk_info_s = emit_left_r;
    else                        blk_info_s = BLK_INFO;
    if (coll_left_r < BLK_INFO) coll_info_s = coll_left_r;
    else                        coll_info_s = BLK_INFO;
    // last bit of the final block is on data_out this cycle
    last_done_s = (state_r == ST_COLLECT) && valid_out_r && (out_rem_r == 4'd0) &&
                  (emit_left_r == {NB_W{1'b0}}) && !blk_full_r;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && (n_bits == {NB_W{1'b0}})) state_s = ST_DONE;
        else if (enable)                        state_s = ST_COLLECT;
        else                                    state_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (!enable)          state_s = ST_IDLE;
        else if (last_done_s) state_s = ST_DONE;
        else                  state_s = ST_COLLECT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Input collection, block hand-off and output streaming.
  always_ff @(posedge clk) begin
    if (reset || ((state_r != ST_IDLE) && !enable)) begin
      rx_sh_r     <= 15'd0;
      bit_cnt_r   <= 4'd0;
      blk_full_r  <= 1'b0;
      coll_left_r <= {NB_W{1'b0}};
      emit_left_r <= {NB_W{1'b0}};
      out_sh_r    <= 9'd0;
      out_rem_r   <= 4'd0;
      valid_out_r <= 1'b0;
      data_out_r  <= 1'b0;
      finished_r  <= 1'b0;
      uncorr_r    <= 1'b0;
    end else begin
      blk_full_r <= 1'b0;
      finished_r <= 1'b0;
      uncorr_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          valid_out_r <= 1'b0;
          data_out_r  <= 1'b0;
          if (enable) begin
            coll_left_r <= n_bits;
            emit_left_r <= n_bits;
            rx_sh_r     <= 15'd0;
            bit_cnt_r   <= 4'd0;
            out_sh_r    <= 9'd0;
            out_rem_r   <= 4'd0;
            finished_r  <= (n_bits == {NB_W{1'b0}});
          end
        end
        ST_COLLECT: begin
          // surplus bits after the last block are dropped (coll_left_r == 0)
          if (valid_in && (coll_left_r != {NB_W{1'b0}})) begin
            rx_sh_r <= {rx_sh_r[13:0], data_in};
            if (bit_cnt_r == 4'd14) begin
              bit_cnt_r   <= 4'd0;
              blk_full_r  <= 1'b1;
              coll_left_r <= coll_left_r - coll_info_s;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          // rx_sh_r still holds the full block here even if a new bit shifts in
          if (blk_full_r) begin
            data_out_r  <= info_corr_s[9];
            out_sh_r    <= info_corr_s[8:0];
            out_rem_r   <= blk_info_s[3:0] - 4'd1;
            emit_left_r <= emit_left_r - blk_info_s;
            valid_out_r <= 1'b1;
            uncorr_r    <= unc_s;
          end else if (out_rem_r != 4'd0) begin
            data_out_r  <= out_sh_r[8];
            out_sh_r    <= {out_sh_r[7:0], 1'b0};
            out_rem_r   <= out_rem_r - 4'd1;
            valid_out_r <= 1'b1;
          end else begin
            data_out_r  <= 1'b0;
            valid_out_r <= 1'b0;
          end
          finished_r <= last_done_s;
        end
        ST_DONE: begin
          valid_out_r <= 1'b0;
          data_out_r  <= 1'b0;
        end
        default: begin
          valid_out_r <= 1'b0;
          data_out_r  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out     = valid_out_r;
  assign data_out      = data_out_r;
  assign finished      = finished_r;
  assign uncorrectable = uncorr_r;

`ifdef BLE_FEC_ERR_STATS_EN
  logic [7:0] corr_cnt_r, unc_cnt_r;

  // Per-packet error statistics, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset || ((state_r == ST_IDLE) && enable)) begin
      corr_cnt_r <= 8'd0;
      unc_cnt_r  <= 8'd0;
    end else if ((state_r == ST_COLLECT) && enable && blk_full_r) begin
      if (loc_s[4] && (corr_cnt_r != 8'hFF)) corr_cnt_r <= corr_cnt_r + 8'd1;
      if (unc_s && (unc_cnt_r != 8'hFF))     unc_cnt_r  <= unc_cnt_r + 8'd1;
    end
  end

  assign corrected_cnt     = corr_cnt_r;
  assign uncorrectable_cnt = unc_cnt_r;
`endif

endmodule

// File: tb/tb_top_controlled_decoder_ble.sv
// tb_top_controlled_decoder_ble
// Self-checking bench for top_controlled_decoder_ble. A packet-level model
// encodes payloads, applies error patterns, decodes by brute-force bit
// flipping and schedules the expected outputs per cycle; one compare
// process checks every cycle. Statistics ports are checked when
// BLE_FEC_ERR_STATS_EN is defined.
module tb_top_controlled_decoder_ble;
  localparam int NB_W = 16;
  localparam int MAXC = 16384;

  logic            clk = 1'b0;
  logic            reset, data_in, valid_in, enable;
  logic [NB_W-1:0] n_bits;
  logic            valid_out, data_out, finished, uncorrectable;
`ifdef BLE_FEC_ERR_STATS_EN
  logic [7:0]      corrected_cnt, uncorrectable_cnt;
`endif

  top_controlled_decoder_ble #(.NB_W(NB_W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .n_bits(n_bits), .enable(enable), .valid_out(valid_out),
    .data_out(data_out), .finished(finished), .uncorrectable(uncorrectable)
`ifdef BLE_FEC_ERR_STATS_EN
    , .corrected_cnt(corrected_cnt), .uncorrectable_cnt(uncorrectable_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit exp_v [MAXC];
  bit exp_d [MAXC];
  bit exp_f [MAXC];
  bit exp_u [MAXC];
  bit chk_en = 1'b0;
  int n_checks = 0;
  int n_pass = 0;
  int pkt_vcnt = 0;
  int pkt_fcnt = 0;
  bit          pay[$];
  logic [14:0] errm[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] model_mod(input logic [14:0] w);
    logic [14:0] r;
    r = w;
    for (int j = 14; j >= 5; j--)
      if (r[j]) r = r ^ (15'b000000000110101 << (j - 5));
    return r[4:0];
  endfunction

  function automatic logic [14:0] model_encode(input logic [9:0] info);
    logic [14:0] w;
    w = {info, 5'd0};
    return w | {10'd0, model_mod(w)};
  endfunction

  task automatic model_decode(input logic [14:0] rx, output logic [9:0] dec,
                              output int unc, output int fix);
    logic [14:0] t;
    dec = rx[14:5];
    unc = 0;
    fix = 0;
    if (model_mod(rx) != 5'd0) begin
      unc = 1;
      for (int i = 0; i < 15; i++) begin
        t = rx ^ (15'd1 << i);
        if (unc == 1 && model_mod(t) == 5'd0) begin
          dec = t[14:5];
          unc = 0;
          fix = 1;
        end
      end
    end
  endtask

  function automatic logic [14:0] rand_mask();
    int kind, a, b;
    kind = $urandom_range(0, 3);
    a    = $urandom_range(0, 14);
    b    = (a + $urandom_range(1, 14)) % 15;
    if (kind < 2)  return 15'd0;
    if (kind == 2) return 15'd1 << a;
    return (15'd1 << a) | (15'd1 << b);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle(input logic v, input logic d);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
  endtask

  task automatic set_pay(input logic [63:0] v, input int nb);
    pay.delete();
    for (int j = 0; j < nb; j++) pay.push_back(v[nb - 1 - j]);
  endtask

  task automatic clear_errs();
    errm.delete();
    repeat (6) errm.push_back(15'd0);
  endtask

  // Runs one packet; abort_after >= 0 drops enable after that many bits,
  // rst_out >= 0 asserts reset while that output bit index is on data_out.
  task automatic run_packet(input int nb, input int abort_after, input int rst_out);
    int nblk, c0, c, fin, k, nsent, first_c, unc, fix, exp_fix, exp_unc;
    bit aborted;
    logic [9:0]  info, dec;
    logic [14:0] rx;
    nblk = (nb + 9) / 10;
    aborted = 1'b0; nsent = 0; fin = -1; first_c = -1; exp_fix = 0; exp_unc = 0;
    next_cycle(1'b1, 1'($urandom));   // valid_in in IDLE is ignored
    enable = 1'b1;
    n_bits = NB_W'(nb);
    c0 = cyc;
    pkt_vcnt = 0;
    pkt_fcnt = 0;
    if (nb == 0) begin
      fin = c0 + 1;
      exp_f[fin] = 1'b1;
    end
    for (int b = 0; b < nblk && !aborted; b++) begin
      k = (nb - 10 * b < 10) ? nb - 10 * b : 10;
      info = 10'd0;
      for (int j = 0; j < k; j++) info[9 - j] = pay[10 * b + j];
      rx = model_encode(info) ^ errm[b];
      model_decode(rx, dec, unc, fix);
      for (int j = 14; j >= 0 && !aborted; j--) begin
        repeat ($urandom_range(0, 2)) next_cycle(1'b0, 1'($urandom));
        if (nsent == abort_after) aborted = 1'b1;
        else begin
          next_cycle(1'b1, rx[j]);
          nsent++;
        end
      end
      if (!aborted) begin
        c = cyc;
        if (first_c < 0) first_c = c;
        exp_u[c + 2] = (unc != 0);
        for (int j = 0; j < k; j++) begin
          exp_v[c + 2 + j] = 1'b1;
          exp_d[c + 2 + j] = dec[9 - j];
        end
        if (b == nblk - 1) begin
          fin = c + 2 + k;
          exp_f[fin] = 1'b1;
        end
        exp_fix += fix;
        exp_unc += unc;
      end
    end
    if (aborted) begin
      next_cycle(1'b0, 1'b0);
      enable = 1'b0;
      repeat (3) next_cycle(1'b0, 1'b0);
      check("abort_valid_cnt", pkt_vcnt, 0);
      check("abort_finished_cnt", pkt_fcnt, 0);
      return;
    end
    // surplus coded bits beyond the last block must be ignored
    for (int e = 0; e < 3; e++)
      if (cyc + 1 <= fin) next_cycle(1'b1, 1'($urandom));
    if (rst_out >= 0) begin
      int r;
      r = first_c + 2 + rst_out;
      while (cyc < r) next_cycle(1'b0, 1'b0);
      reset  = 1'b1;
      enable = 1'b0;
      for (int i = r + 1; i < r + 40; i++) begin
        exp_v[i] = 1'b0; exp_f[i] = 1'b0; exp_u[i] = 1'b0;
      end
      next_cycle(1'b0, 1'b0);
      reset = 1'b0;
      check("rst_mid_outputs", {valid_out, data_out, finished, uncorrectable}, 4'b0000);
      check("rst_mid_valid_cnt", pkt_vcnt, rst_out + 1);
      repeat (3) next_cycle(1'b0, 1'b0);
      return;
    end
    while (cyc < fin + 1) next_cycle(1'b0, 1'b0);
    enable = 1'b0;
    check("pkt_valid_cnt", pkt_vcnt, nb);
    check("pkt_finished_cnt", pkt_fcnt, 1);
`ifdef BLE_FEC_ERR_STATS_EN
    check("corrected_cnt", corrected_cnt, exp_fix);
    check("uncorrectable_cnt", uncorrectable_cnt, exp_unc);
`endif
    next_cycle(1'b0, 1'b0);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && cyc < MAXC) begin
        check("valid_out", valid_out, exp_v[cyc]);
        if (exp_v[cyc]) check("data_out", data_out, exp_d[cyc]);
        check("finished", finished, exp_f[cyc]);
        check("uncorrectable", uncorrectable, exp_u[cyc]);
        if (valid_out === 1'b1) pkt_vcnt++;
        if (finished === 1'b1) pkt_fcnt++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] pdec;
    int punc, pfix, nb;
    reset = 1'b1; enable = 1'b0; valid_in = 1'b0; data_in = 1'b0; n_bits = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_valid_out", valid_out, 1'b0);
    check("reset_data_out", data_out, 1'b0);
    check("reset_finished", finished, 1'b0);
    check("reset_uncorrectable", uncorrectable, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // hand-computed anchors for the model
    check("pin_encode", model_encode(10'b1011001110), 15'b101100111001010);
    check("pin_encode_zero", model_encode(10'd0), 15'd0);
    check("pin_syn_d7", model_mod(15'd1 << 7), 5'b01011);
    check("pin_syn_d7_d2", model_mod(15'b000000010000100), 5'b01111);
    model_decode(15'b101100111001010 ^ (15'd1 << 7), pdec, punc, pfix);
    check("pin_decode_single", {pfix[0], punc[0], pdec}, {2'b10, 10'b1011001110});

    // clean all-zero single block
    set_pay(64'd0, 10); clear_errs();
    run_packet(10, -1, -1);
    // padded three-block packet
    set_pay(64'h155A5A5, 25); clear_errs();
    run_packet(25, -1, -1);
    // single error on D^7
    set_pay(64'b1011001110, 10); clear_errs(); errm[0] = 15'd1 << 7;
    run_packet(10, -1, -1);
    // double error D^7 + D^2
    errm[0] = (15'd1 << 7) | (15'd1 << 2);
    run_packet(10, -1, -1);
    // abort after 8 bits, then a fresh clean packet
    set_pay({$urandom, $urandom}, 20); clear_errs();
    run_packet(20, 8, -1);
    set_pay({$urandom, $urandom}, 20);
    run_packet(20, -1, -1);
    // reset while the 5th output bit is on data_out
    set_pay({$urandom, $urandom}, 10);
    run_packet(10, -1, 4);
    set_pay({$urandom, $urandom}, 13);
    run_packet(13, -1, -1);
    // empty packet
    run_packet(0, -1, -1);
    // randomized packets with random error patterns
    for (int p = 0; p < 15; p++) begin
      nb = $urandom_range(1, 40);
      set_pay({$urandom, $urandom}, nb);
      errm.delete();
      repeat (6) errm.push_back(rand_mask());
      run_packet(nb, -1, -1);
    end

    repeat (3) next_cycle(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
